// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Purpose : bundles the instruction-memory, redirect and decode-side
//           valid/ready signals of the fetch unit into one interface.
// Signals :
//   imem_addr      fetch word address toward instruction memory
//   imem_rd        instruction word returned combinationally for imem_addr
//   redirect_valid control-flow redirect request from execute
//   redirect_pc    redirect target (low two bits ignored by the fetch unit)
//   out_valid      FIFO head holds a valid instruction
//   out_ready      decode accepts the head this cycle
//   out_instr      head instruction word (0 when empty)
//   out_pc         head instruction address (0 when empty)
//   out_pc_plus4   out_pc + 4 modulo 2^32 (0 when empty)
//   level          current FIFO occupancy
// Modports: master = fetch unit side, slave = memory/execute/decode side.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int DEPTH = 2
) ();
   logic [31:0]              imem_addr;
   logic [31:0]              imem_rd;
   logic                     redirect_valid;
   logic [31:0]              redirect_pc;
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_instr;
   logic [31:0]              out_pc;
   logic [31:0]              out_pc_plus4;
   logic [$clog2(DEPTH):0]   level;

   modport master (
      output imem_addr,
      input  imem_rd,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_pc_plus4,
      output level
   );

   modport slave (
      input  imem_addr,
      output imem_rd,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_pc_plus4,
      input  level
   );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Purpose : instruction-fetch initiator. Drives the pc onto imem_addr,
//           captures the combinational memory word each cycle into a small
//           in-order FIFO of {instr, pc} pairs and presents the head to
//           decode over valid/ready. A redirect flushes the FIFO and restarts
//           fetch at the (word-aligned) target.
// Ports   :
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - fetch_unit_if.master (memory, redirect and decode signals)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);
   localparam int             PW         = $clog2(DEPTH);
   localparam int             LW         = PW + 1;
   localparam logic [LW-1:0]  FULL_LEVEL = LW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_unit: DEPTH must be a power of two, at least 2");
   end
   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("fetch_unit: RESET_PC must be word aligned");
   end

   logic [31:0]    r_pc;
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [LW-1:0]  r_level;
   logic [31:0]    r_instr_mem [DEPTH];
   logic [31:0]    r_pc_mem    [DEPTH];

   logic           w_valid;
   logic           w_pop;
   logic           w_can_push;
   logic           w_push;
   logic [LW-1:0]  w_level_next;

   assign w_valid    = (r_level != '0);
   assign w_pop      = w_valid & bus.out_ready;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign w_can_push = (r_level < FULL_LEVEL) | w_pop;
   assign w_push     = ~bus.redirect_valid & w_can_push;

   always_comb begin
      w_level_next = r_level;
      if (w_push && !w_pop) begin
         w_level_next = r_level + LW'(1);
      end else if (!w_push && w_pop) begin
         w_level_next = r_level - LW'(1);
      end
   end

   // Control state: pc, pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc     <= RESET_PC;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (bus.redirect_valid) begin
         // Any same-cycle pop has already been seen by decode; the rest of
         // the FIFO content is stale and dropped.
         r_pc     <= bus.redirect_pc & 32'hFFFF_FFFC;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_pc     <= r_pc + 32'd4;
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_level <= w_level_next;
      end
   end

   // Entry storage needs no reset: outputs are gated by occupancy.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= bus.imem_rd;
         r_pc_mem[r_wr_ptr]    <= r_pc;
      end
   end

   assign bus.imem_addr    = r_pc;
   assign bus.out_valid    = w_valid;
   assign bus.out_instr    = w_valid ? r_instr_mem[r_rd_ptr] : 32'd0;
   assign bus.out_pc       = w_valid ? r_pc_mem[r_rd_ptr] : 32'd0;
   assign bus.out_pc_plus4 = w_valid ? (r_pc_mem[r_rd_ptr] + 32'd4) : 32'd0;
   assign bus.level        = r_level;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator that drives the word address into the combinational instruction memory and captures the returned instruction word each cycle.
- Fetched {instr, pc} pairs are buffered in a small in-order FIFO and presented to decode over a valid/ready interface.
- Supports a single-cycle control-flow redirect (branch/jump from execute) that flushes the buffer and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals internal pc register.
- imem_rd  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  input  1  redirect request from execute.
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0 internally.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  32  head instruction address.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC; FIFO empty; level = 0; out_valid = 0.
  - out_instr, out_pc and out_pc_plus4 all read 0.
- imem_addr is driven directly from the pc register; no combinational path from any input.
- pop = out_valid & out_ready.
- can_push = (level < DEPTH) | pop.
- Priority 1, redirect_valid=1:
  - At the clock edge, the FIFO is cleared (level = 0) and pc <= {redirect_pc[31:2], 2'b00}.
  - No push occurs in the redirect cycle.
  - A pop in the same cycle counts as delivered to the consumer; the producer side discards the rest.
  - Back-to-back redirects: the last one wins; nothing is pushed in any of those cycles.
- Priority 2, no redirect and can_push=1:
  - Push {imem_rd, pc} at the tail; pc <= pc + 4.
  - pc wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Priority 3, no redirect and can_push=0:
  - pc holds; imem_rd is ignored.
  - imem_addr is stable, so the same word is re-read and captured once space frees.
- Full FIFO with a pop in the same cycle: push and pop both occur; level is unchanged.
- Empty FIFO with out_ready=1: no pop; level increments if a push occurs.
- Timing and ordering:
  - Outputs out_* are driven from FIFO head registers; no combinational path from imem_rd to out_*.
  - Fetch-to-decode latency is 1 cycle: a word captured at edge N is visible with out_valid=1 after edge N.
  - In steady state (out_ready held 1) throughput is one instruction per cycle with no bubbles.
  - Entries leave strictly in push order.
- When the FIFO is empty, out_instr, out_pc and out_pc_plus4 read 0.
- Reset mid-operation: all state returns to reset values immediately (asynchronously); the first fetch after deassertion is at RESET_PC.
- level never exceeds DEPTH. Read/write pointers wrap modulo DEPTH; full and empty are distinguished by level, not pointer equality.

Test Plan:
- Reset release, memory words 0..5 = FFC4A303, 00832383, 0064A423, 00B62423, 0062E233, 00B62423, out_ready=1 -> edge 1: out_valid=1, out_pc=0, out_instr=FFC4A303, out_pc_plus4=4; edge 2: out_pc=4, out_instr=00832383; one instruction per cycle thereafter.
- out_ready=0 from reset, DEPTH=2 -> level reaches 2 after 2 edges; imem_addr stays 8 while full; raising out_ready for one cycle then yields head pc 0 popped, pc 8 pushed, level stays 2, imem_addr becomes C.
- Redirect with level=2 at pc=C, redirect_pc=32'h0000_0012 -> next cycle level=0, out_valid=0, imem_addr=10; the following cycle out_pc=10.
- Redirect asserted together with a pop (out_ready=1, out_pc=4) -> pc 4 is counted as delivered once; no entry with pc 8 appears afterwards; the next out_pc is the redirect target.
- Wrap: redirect_pc=FFFF_FFF8, out_ready=1 -> delivered out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus4 for FFFF_FFFC reads 0.
- Assert rst=0 mid-stream with level=2, between edges -> out_valid, level and out_* drop to 0 immediately; after release, the first out_pc is RESET_PC.
